// File: rtl/mm_drain_pkg.sv
// Shared constants, word-select helper and response-error encoding for the result drain.
package mm_drain_pkg;

  localparam int ROW_W      = 128;
  localparam int WORD_W     = 32;
  localparam int WORDS      = ROW_W / WORD_W;
  localparam int WORD_SEL_W = $clog2(WORDS);

  typedef enum logic {
    RSP_OK  = 1'b0,
    RSP_ERR = 1'b1
  } rsp_err_e;

  // Word 0 is the most-significant slice of the row.
  function automatic logic [WORD_W-1:0] word_select(input logic [ROW_W-1:0]      row,
                                                    input logic [WORD_SEL_W-1:0] sel);
    int base;
    base = (WORDS - 1 - int'(sel)) * WORD_W;
    return row[base +: WORD_W];
  endfunction

endpackage

// File: rtl/mm_drain_bank.sv
// One result bank: row storage, per-row written flags and unique-row counter.
// Optional overwrite strobe is present when MM_DRAIN_OVERWRITE_CNT_EN is defined.
module mm_drain_bank
  import mm_drain_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int ROW_W      = 128
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [ROW_W-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ROW_W-1:0]      rd_row,
  output logic                  rd_ok,
  output logic [ADDR_WIDTH:0]   rows_written
`ifdef MM_DRAIN_OVERWRITE_CNT_EN
  ,
  output logic                  overwrite
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);

  logic [ROW_W-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0]    r_flag;
  logic [ADDR_WIDTH:0] r_count;
  logic                w_hit_flag;
  logic                w_rd_bypass;

  assign w_hit_flag = r_flag[wr_addr];

  always_ff @(posedge clock) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // A write in the same cycle as clear survives: it is applied after the wipe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_flag  <= '0;
      r_count <= '0;
    end else begin
      if (clear) r_flag <= '0;
      if (wr_en) r_flag[wr_addr] <= 1'b1;
      if (clear)
        r_count <= wr_en ? CNT_ONE : '0;
      else if (wr_en && !w_hit_flag)
        r_count <= r_count + CNT_ONE;
    end
  end

  // Read port sees this cycle's write and this cycle's clear.
  assign w_rd_bypass  = wr_en && (wr_addr == rd_addr);
  assign rd_row       = w_rd_bypass ? wr_data : r_mem[rd_addr];
  assign rd_ok        = w_rd_bypass || (!clear && r_flag[rd_addr]);
  assign rows_written = r_count;

`ifdef MM_DRAIN_OVERWRITE_CNT_EN
  assign overwrite = wr_en && w_hit_flag && !clear;
`endif

endmodule

// File: rtl/mm_result_drain.sv
// Captures the c0/c1/c2 result write streams and serves rows back as 32-bit words.
// Define MM_DRAIN_OVERWRITE_CNT_EN to add the saturating overwrite_cnt output.
module mm_result_drain
  import mm_drain_pkg::*;
#(
  parameter int ARRAY_SIZE        = 8,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int ADDR_WIDTH        = 6,
  parameter int NUM_BANKS         = 3,
  parameter int WORD_WIDTH        = 32
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NUM_BANKS-1:0]                   wr_en,
  input  logic [NUM_BANKS*ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0]        wr_addr,
  input  logic                                   clear,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic [1:0]                             req_bank,
  input  logic [ADDR_WIDTH-1:0]                  req_addr,
  input  logic [$clog2(ARRAY_SIZE*OUTPUT_DATA_WIDTH/WORD_WIDTH)-1:0] req_word,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  output logic [WORD_WIDTH-1:0]                  rsp_data,
  output logic                                   rsp_err,
  output logic [NUM_BANKS*(ADDR_WIDTH+1)-1:0]    rows_written
`ifdef MM_DRAIN_OVERWRITE_CNT_EN
  ,
  output logic [15:0]                            overwrite_cnt
`endif
);

  localparam int ROW_W_P = ARRAY_SIZE * OUTPUT_DATA_WIDTH;

  logic [ROW_W_P-1:0]    w_rd_row [NUM_BANKS];
  logic [NUM_BANKS-1:0]  w_rd_ok;
  logic [ROW_W_P-1:0]    w_sel_row;
  logic                  w_sel_ok;
  logic                  w_accept;

  logic                  r_rsp_vld_p1;
  logic [WORD_WIDTH-1:0] r_rsp_data_p1;
  rsp_err_e              r_rsp_err_p1;

`ifdef MM_DRAIN_OVERWRITE_CNT_EN
  logic [NUM_BANKS-1:0]  w_ovw;
`endif

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    mm_drain_bank #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .ROW_W     (ROW_W_P)
    ) u_bank (
      .clock       (clock),
      .reset       (reset),
      .clear       (clear),
      .wr_en       (wr_en[g]),
      .wr_addr     (wr_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .wr_data     (wr_data[g*ROW_W_P +: ROW_W_P]),
      .rd_addr     (req_addr),
      .rd_row      (w_rd_row[g]),
      .rd_ok       (w_rd_ok[g]),
      .rows_written(rows_written[g*(ADDR_WIDTH+1) +: ADDR_WIDTH+1])
`ifdef MM_DRAIN_OVERWRITE_CNT_EN
      ,
      .overwrite   (w_ovw[g])
`endif
    );
  end

  // An out-of-range bank select leaves w_sel_ok low, which reports as an error.
  always_comb begin
    w_sel_row = '0;
    w_sel_ok  = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (int'(req_bank) == b) begin
        w_sel_row = w_rd_row[b];
        w_sel_ok  = w_rd_ok[b];
      end
    end
  end

  assign req_ready = !r_rsp_vld_p1 || rsp_ready;
  assign w_accept  = req_valid && req_ready;

  // p0 -> p1: single-entry response register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rsp_vld_p1  <= 1'b0;
      r_rsp_data_p1 <= '0;
      r_rsp_err_p1  <= RSP_OK;
    end else if (w_accept) begin
      r_rsp_vld_p1  <= 1'b1;
      r_rsp_data_p1 <= w_sel_ok ? word_select(w_sel_row, req_word) : '0;
      r_rsp_err_p1  <= w_sel_ok ? RSP_OK : RSP_ERR;
    end else if (rsp_ready) begin
      r_rsp_vld_p1  <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_vld_p1;
  assign rsp_data  = r_rsp_data_p1;
  assign rsp_err   = (r_rsp_err_p1 == RSP_ERR);

`ifdef MM_DRAIN_OVERWRITE_CNT_EN
  localparam int OVW_NUM_W = $clog2(NUM_BANKS + 1);

  logic [OVW_NUM_W-1:0] w_ovw_num;
  logic [15:0]          r_ovw_cnt;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [OVW_NUM_W-1:0] n);
    logic [16:0] s;
    s = {1'b0, a} + 17'(n);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    w_ovw_num = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      w_ovw_num = w_ovw_num + OVW_NUM_W'(w_ovw[b]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      r_ovw_cnt <= '0;
    else if (clear) r_ovw_cnt <= '0;
    else            r_ovw_cnt <= sat_add(r_ovw_cnt, w_ovw_num);
  end

  assign overwrite_cnt = r_ovw_cnt;
`endif

endmodule

// File: tb/tb_mm_result_drain.sv
// Directed bench for mm_result_drain with a per-cycle reference model and literal spot checks.
module tb_mm_result_drain;

  logic         clock;
  logic         reset;
  logic [2:0]   wr_en;
  logic [383:0] wr_data;
  logic [17:0]  wr_addr;
  logic         clear;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_bank;
  logic [5:0]   req_addr;
  logic [1:0]   req_word;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_data;
  logic         rsp_err;
  logic [20:0]  rows_written;
`ifdef MM_DRAIN_OVERWRITE_CNT_EN
  logic [15:0]  overwrite_cnt;
`endif

  int checks = 0;
  int errors = 0;

  mm_result_drain dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_addr     (wr_addr),
    .clear       (clear),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_bank    (req_bank),
    .req_addr    (req_addr),
    .req_word    (req_word),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .rows_written(rows_written)
`ifdef MM_DRAIN_OVERWRITE_CNT_EN
    ,
    .overwrite_cnt(overwrite_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: result store as plain arrays, response as the last accepted read.
  logic [127:0] m_mem  [3][64];
  bit           m_flag [3][64];
  int           m_cnt  [3];
  int           m_ovw;
  logic         m_vld;
  logic [31:0]  m_data;
  logic         m_err;

  always @(posedge clock or posedge reset) begin : model
    logic acc;
    int   a;
    if (reset) begin
      for (int b = 0; b < 3; b++) begin
        m_cnt[b] = 0;
        for (int r = 0; r < 64; r++) m_flag[b][r] = 1'b0;
      end
      m_ovw  = 0;
      m_vld  = 1'b0;
      m_data = '0;
      m_err  = 1'b0;
    end else begin
      acc = req_valid && (!m_vld || rsp_ready);
      if (clear) begin
        for (int b = 0; b < 3; b++) begin
          m_cnt[b] = 0;
          for (int r = 0; r < 64; r++) m_flag[b][r] = 1'b0;
        end
        m_ovw = 0;
      end
      for (int b = 0; b < 3; b++) begin
        if (wr_en[b]) begin
          a = int'(wr_addr[b*6 +: 6]);
          if (m_flag[b][a]) m_ovw = (m_ovw < 65535) ? m_ovw + 1 : 65535;
          else              m_cnt[b] = m_cnt[b] + 1;
          m_flag[b][a] = 1'b1;
          m_mem[b][a]  = wr_data[b*128 +: 128];
        end
      end
      if (acc) begin
        m_vld = 1'b1;
        if (req_bank < 2'd3 && m_flag[req_bank][req_addr]) begin
          m_err  = 1'b0;
          m_data = 32'(m_mem[req_bank][req_addr] >> (32 * (3 - int'(req_word))));
        end else begin
          m_err  = 1'b1;
          m_data = '0;
        end
      end else if (rsp_ready) begin
        m_vld = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    if (reset) return;
    chk("req_ready", 64'(req_ready), 64'(!m_vld || rsp_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_vld));
    if (m_vld) begin
      chk("rsp_data", 64'(rsp_data), 64'(m_data));
      chk("rsp_err", 64'(rsp_err), 64'(m_err));
    end
    for (int b = 0; b < 3; b++)
      chk("rows_written", 64'(rows_written[b*7 +: 7]), 64'(m_cnt[b]));
`ifdef MM_DRAIN_OVERWRITE_CNT_EN
    chk("overwrite_cnt", 64'(overwrite_cnt), 64'(m_ovw));
`endif
  endtask

  // Compare at the falling edge, then step past the next rising edge.
  task automatic tick();
    @(negedge clock);
    cmp_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input int b, input int a, input int w);
    req_valid = 1'b1;
    req_bank  = 2'(b);
    req_addr  = 6'(a);
    req_word  = 2'(w);
  endtask

  function automatic logic [127:0] row_pat(input int b, input int a);
    return {32'(b * 1000 + a), 32'(a), 32'hA5A5_0000 | 32'(a), 32'(b)};
  endfunction

  localparam logic [127:0] D = 128'h0123_4567_89AB_CDEF_1111_2222_3333_4444;
  localparam logic [127:0] X = 128'hFEDC_BA98_7654_3210_0F0F_0F0F_CAFE_F00D;
  localparam logic [127:0] Y = 128'h1357_9BDF_2468_ACE0_DEAD_BEEF_0BAD_F00D;

  initial begin
    reset = 1'b1; wr_en = '0; wr_data = '0; wr_addr = '0; clear = 1'b0;
    req_valid = 1'b0; req_bank = '0; req_addr = '0; req_word = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    chk("reset_rsp_err", 64'(rsp_err), 64'd0);
    chk("reset_rows_written", 64'(rows_written), 64'd0);
    #2 reset = 1'b0;
    rsp_ready = 1'b1;

    // Single write then two word reads
    wr_en = 3'b001; wr_addr[5:0] = 6'd5; wr_data[127:0] = D;
    tick();
    wr_en = '0;
    req(0, 5, 0); tick();
    chk("w0_valid", 64'(rsp_valid), 64'd1);
    chk("w0_data", 64'(rsp_data), 64'h0123_4567);
    chk("w0_err", 64'(rsp_err), 64'd0);
    req(0, 5, 3); tick();
    chk("w3_data", 64'(rsp_data), 64'h3333_4444);
    req_valid = 1'b0; tick();
    chk("drain_valid", 64'(rsp_valid), 64'd0);

    // Unwritten row and out-of-range bank
    req(1, 7, 0); tick();
    chk("unwritten_err", 64'(rsp_err), 64'd1);
    chk("unwritten_data", 64'(rsp_data), 64'd0);
    req(3, 5, 0); tick();
    chk("bank3_err", 64'(rsp_err), 64'd1);
    req_valid = 1'b0; tick();

    // Clear together with a read of a written row
    clear = 1'b1; req(0, 5, 0); tick();
    clear = 1'b0; req_valid = 1'b0;
    chk("clear_read_err", 64'(rsp_err), 64'd1);
    tick();
    chk("clear_rows", 64'(rows_written), 64'd0);

    // Fill all banks, addr 10 written twice
    for (int i = 0; i <= 64; i++) begin
      int aa;
      aa = (i == 64) ? 10 : i;
      wr_en = 3'b111;
      for (int b = 0; b < 3; b++) begin
        wr_addr[b*6 +: 6]   = 6'(aa);
        wr_data[b*128 +: 128] = row_pat(b, aa);
      end
      tick();
    end
    wr_en = '0; tick();
    chk("fill_rows_b0", 64'(rows_written[6:0]), 64'd64);
    chk("fill_rows_b1", 64'(rows_written[13:7]), 64'd64);
    chk("fill_rows_b2", 64'(rows_written[20:14]), 64'd64);
`ifdef MM_DRAIN_OVERWRITE_CNT_EN
    chk("fill_ovw", 64'(overwrite_cnt), 64'd3);
`endif

    // Backpressure: hold, then drain back-to-back
    rsp_ready = 1'b0;
    req(0, 20, 1); tick();
    chk("held_first", 64'(rsp_data), 64'h14);
    for (int i = 0; i < 4; i++) begin
      req(1, 30 + i, 0); tick();
      chk("held_ready", 64'(req_ready), 64'd0);
      chk("held_data", 64'(rsp_data), 64'h14);
      chk("held_valid", 64'(rsp_valid), 64'd1);
    end
    rsp_ready = 1'b1;
    req(2, 40, 0); tick(); chk("b2b_0", 64'(rsp_data), 64'h7F8);
    req(2, 41, 1); tick(); chk("b2b_1", 64'(rsp_data), 64'h29);
    req(2, 42, 2); tick(); chk("b2b_2", 64'(rsp_data), 64'hA5A5_002A);
    req(2, 43, 3); tick(); chk("b2b_3", 64'(rsp_data), 64'h2);
    req_valid = 1'b0; tick();

    // Write-first on a same-cycle read
    wr_en = 3'b100; wr_addr[17:12] = 6'd3; wr_data[383:256] = X;
    req(2, 3, 2); tick();
    wr_en = '0; req_valid = 1'b0;
    chk("wfirst_data", 64'(rsp_data), 64'h0F0F_0F0F);
    chk("wfirst_err", 64'(rsp_err), 64'd0);
`ifdef MM_DRAIN_OVERWRITE_CNT_EN
    chk("wfirst_ovw", 64'(overwrite_cnt), 64'd4);
`endif

    // Clear and write of one row in the same cycle, with a read of it
    clear = 1'b1; wr_en = 3'b010; wr_addr[11:6] = 6'd9; wr_data[255:128] = Y;
    req(1, 9, 3); tick();
    clear = 1'b0; wr_en = '0; req_valid = 1'b0;
    chk("clrwr_data", 64'(rsp_data), 64'h0BAD_F00D);
    chk("clrwr_err", 64'(rsp_err), 64'd0);
    tick();
    chk("clrwr_rows_b1", 64'(rows_written[13:7]), 64'd1);
    chk("clrwr_rows_b0", 64'(rows_written[6:0]), 64'd0);
    req(1, 8, 0); tick(); chk("clrwr_other_err", 64'(rsp_err), 64'd1);
    req(1, 9, 0); tick(); chk("clrwr_row_data", 64'(rsp_data), 64'h1357_9BDF);
    req_valid = 1'b0; tick();

    // Asynchronous reset with a pending response
    rsp_ready = 1'b0;
    req(1, 9, 1); tick();
    req_valid = 1'b0;
    chk("pre_reset_valid", 64'(rsp_valid), 64'd1);
    #3 reset = 1'b1;
    #1;
    chk("async_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("async_rows", 64'(rows_written), 64'd0);
    #2 reset = 1'b0;
    rsp_ready = 1'b1;
    req(1, 9, 1); tick();
    chk("post_reset_err", 64'(rsp_err), 64'd1);
    chk("post_reset_data", 64'(rsp_data), 64'd0);
    req_valid = 1'b0; tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
